// File: rtl/gpmc_event_regs.sv
// GPMC-side register bank: ID, sticky W1C event status, interrupt mask,
// saturating per-event counters and N_CTRL strobed control registers.
//
// Ports:
//   clk, reset           : gpmc_clk domain clock, synchronous active-high reset
//   address_valid        : qualifies reads; rd_data is zero otherwise
//   address              : byte address, exact match against BASE_ADDR+offset
//   wr_en, wr_data       : single-cycle write strobe and data
//   rd_data              : registered read data, zero when not selected
//   events               : per-cycle event pulses (already in clk domain)
//   irq                  : registered OR of (STATUS & MASK)
//   ctrl_out             : CTRL[k] at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   ctrl_strobe          : one-cycle pulse after each CTRL[k] write
module gpmc_event_regs #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0010,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'hC10D,
    parameter int                    N_EVENTS   = 4,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    N_CTRL     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         address_valid,
    input  logic [ADDR_WIDTH-1:0]        address,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic [N_EVENTS-1:0]          events,
    output logic                         irq,
    output logic [N_CTRL*DATA_WIDTH-1:0] ctrl_out,
    output logic [N_CTRL-1:0]            ctrl_strobe
);

    function automatic logic [ADDR_WIDTH-1:0] f_addr(input int off);
        return BASE_ADDR + ADDR_WIDTH'(off);
    endfunction

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_irq;
    logic [N_EVENTS-1:0]   r_status;
    logic [N_EVENTS-1:0]   r_mask;
    logic [4:0]            r_cnt_sel;
    logic [CNT_WIDTH-1:0]  r_cnt [N_EVENTS];
    logic [DATA_WIDTH-1:0] r_ctrl [N_CTRL];
    logic [N_CTRL-1:0]     r_strobe;

    logic                  w_hit_id;
    logic                  w_hit_status;
    logic                  w_hit_mask;
    logic                  w_hit_sel;
    logic                  w_hit_count;
    logic [N_CTRL-1:0]     w_hit_ctrl;
    logic [N_EVENTS-1:0]   w_status_clr;
    logic                  w_cnt_wr;
    logic [DATA_WIDTH-1:0] w_cnt_rd;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_hit_id     = (address == f_addr(0));
    assign w_hit_status = (address == f_addr(2));
    assign w_hit_mask   = (address == f_addr(4));
    assign w_hit_sel    = (address == f_addr(6));
    assign w_hit_count  = (address == f_addr(8));

    always_comb begin
        w_hit_ctrl = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            w_hit_ctrl[k] = (address == f_addr(10 + 2 * k));
        end
    end

    assign w_status_clr = (wr_en && w_hit_status) ? wr_data[N_EVENTS-1:0] : '0;
    assign w_cnt_wr     = wr_en && w_hit_count;

    // CNT_SEL values with no counter behind them read as zero.
    always_comb begin
        w_cnt_rd = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            if (r_cnt_sel == 5'(i)) begin
                w_cnt_rd = DATA_WIDTH'(r_cnt[i]);
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_hit_id)     w_rd_mux = ID_VALUE;
        if (w_hit_status) w_rd_mux = DATA_WIDTH'(r_status);
        if (w_hit_mask)   w_rd_mux = DATA_WIDTH'(r_mask);
        if (w_hit_sel)    w_rd_mux = DATA_WIDTH'(r_cnt_sel);
        if (w_hit_count)  w_rd_mux = w_cnt_rd;
        for (int k = 0; k < N_CTRL; k++) begin
            if (w_hit_ctrl[k]) w_rd_mux = r_ctrl[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
            r_irq     <= 1'b0;
            r_status  <= '0;
            r_mask    <= '0;
            r_cnt_sel <= '0;
            r_strobe  <= '0;
            for (int i = 0; i < N_EVENTS; i++) r_cnt[i] <= '0;
            for (int k = 0; k < N_CTRL; k++) r_ctrl[k] <= '0;
        end else begin
            r_rd_data <= address_valid ? w_rd_mux : '0;
            r_irq     <= |(r_status & r_mask);
            // Set has priority over a concurrent W1C.
            r_status  <= (r_status & ~w_status_clr) | events;
            if (wr_en && w_hit_mask) r_mask <= wr_data[N_EVENTS-1:0];
            if (wr_en && w_hit_sel)  r_cnt_sel <= wr_data[4:0];
            for (int i = 0; i < N_EVENTS; i++) begin
                if (w_cnt_wr && r_cnt_sel == 5'(i)) begin
                    // A clear that coincides with an event counts that event.
                    r_cnt[i] <= events[i] ? CNT_WIDTH'(1) : '0;
                end else if (events[i] && r_cnt[i] != {CNT_WIDTH{1'b1}}) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
            for (int k = 0; k < N_CTRL; k++) begin
                r_strobe[k] <= wr_en && w_hit_ctrl[k];
                if (wr_en && w_hit_ctrl[k]) r_ctrl[k] <= wr_data;
            end
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[k];
        end
    end

    assign rd_data     = r_rd_data;
    assign irq         = r_irq;
    assign ctrl_strobe = r_strobe;

endmodule

// File: tb/tb_gpmc_event_regs.sv
// Bench for gpmc_event_regs: read results go through a scoreboard queue,
// side outputs (irq, ctrl_out, ctrl_strobe) are checked after the edge.
module tb_gpmc_event_regs;

    localparam logic [15:0] B      = 16'h0010;
    localparam logic [15:0] A_ID   = B + 16'd0;
    localparam logic [15:0] A_STAT = B + 16'd2;
    localparam logic [15:0] A_MASK = B + 16'd4;
    localparam logic [15:0] A_SEL  = B + 16'd6;
    localparam logic [15:0] A_CNT  = B + 16'd8;
    localparam logic [15:0] A_C0   = B + 16'd10;
    localparam logic [15:0] A_C1   = B + 16'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic        address_valid;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic [3:0]  events;
    logic        irq;
    logic [31:0] ctrl_out;
    logic [1:0]  ctrl_strobe;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic        av;
        logic [15:0] addr;
        logic [15:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    gpmc_event_regs #(.CNT_WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .address_valid(address_valid),
        .address(address),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .events(events),
        .irq(irq),
        .ctrl_out(ctrl_out),
        .ctrl_strobe(ctrl_strobe)
    );

    task automatic ck(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Each queued read result is due right after the next rising edge.
    always @(posedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            #1;
            ck(e.name, {16'h0, rd_data}, {16'h0, e.exp});
        end
    end

    task automatic cyc(input logic rst, input logic av,
                       input logic [15:0] a, input logic we,
                       input logic [15:0] wd, input logic [3:0] ev);
        @(negedge clk);
        reset = rst;
        address_valid = av;
        address = a;
        wr_en = we;
        wr_data = wd;
        events = ev;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                      input string n);
        exp_t e;
        cyc(1'b0, 1'b1, a, 1'b0, 16'h0, 4'h0);
        e.exp = exp;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b0, 1'b0, a, 1'b1, d, 4'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        exp_t e;
        int   n;

        tbl[0] = '{1'b1, A_ID,   16'hC10D};
        tbl[1] = '{1'b1, A_C1,   16'h0000};
        tbl[2] = '{1'b1, B + 16'd14, 16'h0000};
        tbl[3] = '{1'b0, A_ID,   16'h0000};
        tbl[4] = '{1'b1, B + 16'd1, 16'h0000};
        tbl[5] = '{1'b1, A_STAT, 16'h0000};
        tbl[6] = '{1'b1, A_MASK, 16'h0000};
        tbl[7] = '{1'b1, A_SEL,  16'h0000};
        tbl[8] = '{1'b1, 16'h0000, 16'h0000};
        tbl[9] = '{1'b1, A_ID,   16'hC10D};

        reset = 1'b1;
        address_valid = 1'b0;
        address = 16'h0;
        wr_en = 1'b0;
        wr_data = 16'h0;
        events = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        ck("rst_rd_data", {16'h0, rd_data}, 32'h0);
        ck("rst_irq", {31'h0, irq}, 32'h0);
        ck("rst_ctrl_out", ctrl_out, 32'h0);
        ck("rst_strobe", {30'h0, ctrl_strobe}, 32'h0);

        // Reset-state and decode vectors.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, tbl[i].av, tbl[i].addr, 1'b0, 16'h0, 4'h0);
            e.exp = tbl[i].exp;
            e.name = $sformatf("vec%0d", i);
            q.push_back(e);
        end

        // Sticky status, mask and irq.
        repeat (3) cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 4'h4);
        wr(A_MASK, 16'h0004);
        rd(A_STAT, 16'h0004, "status_set");
        after_edge();
        ck("irq_set", {31'h0, irq}, 32'h1);
        rd(A_MASK, 16'h0004, "mask_rd");
        wr(A_STAT, 16'h0004);
        after_edge();
        ck("irq_hold", {31'h0, irq}, 32'h1);
        idle();
        after_edge();
        ck("irq_clr", {31'h0, irq}, 32'h0);
        rd(A_STAT, 16'h0000, "status_clr");

        // Set beats clear in the same cycle.
        cyc(1'b0, 1'b0, A_STAT, 1'b1, 16'h0002, 4'h2);
        rd(A_STAT, 16'h0002, "set_wins");
        wr(A_STAT, 16'hFFFF);
        rd(A_STAT, 16'h0000, "w1c_all");

        // Saturating counters.
        wr(A_SEL, 16'h0000);
        repeat (10) cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 4'h1);
        rd(A_CNT, 16'd10, "cnt_10");
        repeat (10) cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 4'h1);
        rd(A_CNT, 16'd15, "cnt_sat");
        wr(A_CNT, 16'h0);
        rd(A_CNT, 16'd0, "cnt_clr");
        wr(A_SEL, 16'h0002);
        rd(A_CNT, 16'd3, "cnt2");
        cyc(1'b0, 1'b0, A_CNT, 1'b1, 16'h0, 4'h4);
        rd(A_CNT, 16'd1, "cnt_clr_evt");
        wr(A_SEL, 16'h0007);
        rd(A_SEL, 16'h0007, "sel_rd");
        rd(A_CNT, 16'd0, "cnt_sel7");
        wr(A_CNT, 16'h0);
        wr(A_SEL, 16'h0002);
        rd(A_CNT, 16'd1, "cnt_sel7_wr_ignored");
        wr(A_STAT, 16'hFFFF);

        // Control registers and strobes.
        wr(A_C1, 16'hBEEF);
        after_edge();
        ck("ctrl1_out", {16'h0, ctrl_out[31:16]}, 32'hBEEF);
        ck("ctrl1_strobe", {30'h0, ctrl_strobe}, 32'h2);
        idle();
        after_edge();
        ck("ctrl1_strobe_off", {30'h0, ctrl_strobe}, 32'h0);
        wr(A_C0, 16'h1111);
        after_edge();
        ck("ctrl0_strobe_a", {30'h0, ctrl_strobe}, 32'h1);
        ck("ctrl0_out_a", {16'h0, ctrl_out[15:0]}, 32'h1111);
        wr(A_C0, 16'h2222);
        after_edge();
        ck("ctrl0_strobe_b", {30'h0, ctrl_strobe}, 32'h1);
        ck("ctrl0_out_b", {16'h0, ctrl_out[15:0]}, 32'h2222);
        idle();
        after_edge();
        ck("ctrl0_strobe_off", {30'h0, ctrl_strobe}, 32'h0);
        rd(A_C1, 16'hBEEF, "ctrl1_rd");

        // Reset mid-operation overrides writes and events.
        repeat (2) cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 4'hF);
        wr(A_MASK, 16'h000F);
        idle();
        after_edge();
        ck("irq_pre_rst", {31'h0, irq}, 32'h1);
        cyc(1'b1, 1'b1, A_C0, 1'b1, 16'hABCD, 4'hF);
        e.exp = 16'h0000;
        e.name = "rd_in_rst";
        q.push_back(e);
        after_edge();
        ck("rst_irq2", {31'h0, irq}, 32'h0);
        ck("rst_ctrl2", ctrl_out, 32'h0);
        ck("rst_strobe2", {30'h0, ctrl_strobe}, 32'h0);
        rd(A_STAT, 16'h0000, "rst_status");
        rd(A_MASK, 16'h0000, "rst_mask");
        rd(A_SEL,  16'h0000, "rst_sel");
        rd(A_CNT,  16'h0000, "rst_cnt0");
        rd(A_C0,   16'h0000, "rst_ctrl0");
        idle();

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
